// File: rtl/add_order_encoder_if.sv
// add_order_encoder_if: field-bundle input handshake plus byte-stream output
// handshake of the ITCH Add Order encoder. The encoder owns the master side.
interface add_order_encoder_if;
    // field bundle (valid/ready)
    logic        in_valid;
    logic        in_ready;
    logic [63:0] order_ref;
    logic        buy_sell;
    logic [31:0] shares;
    logic [31:0] stock;
    logic [31:0] price;

    // byte stream (valid/ready)
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    // completed-message counter
    logic [15:0] msg_count;

    modport master (
        input  in_valid,
        input  order_ref,
        input  buy_sell,
        input  shares,
        input  stock,
        input  price,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_byte,
        output out_last,
        output msg_count
    );

    modport slave (
        output in_valid,
        output order_ref,
        output buy_sell,
        output shares,
        output stock,
        output price,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_byte,
        input  out_last,
        input  msg_count
    );
endinterface

// File: rtl/add_order_encoder.sv
// add_order_encoder: serializes one ITCH 'A' (Add Order) message from parallel
// fields into a big-endian byte stream with valid/ready flow control.
// Optional feature macro: ADD_ORDER_ENC_LEN_PREFIX_EN prepends the 2-byte
// length prefix 0x00 0x16 to every message (24 bytes instead of 22).
module add_order_encoder #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic                clk,
    input  logic                rst,
    add_order_encoder_if.master bus
);

`ifdef ADD_ORDER_ENC_LEN_PREFIX_EN
    localparam int unsigned PREFIX_LEN = 2;
`else
    localparam int unsigned PREFIX_LEN = 0;
`endif
    localparam int unsigned BODY_LEN = 22;
    localparam int unsigned MSG_LEN  = PREFIX_LEN + BODY_LEN;
    localparam int unsigned MSG_BITS = MSG_LEN * 8;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned GAP_W    = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SEL_W    = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0]      shd_order_ref_q, shd_order_ref_d;
    logic             shd_buy_sell_q, shd_buy_sell_d;
    logic [31:0]      shd_shares_q, shd_shares_d;
    logic [31:0]      shd_stock_q, shd_stock_d;
    logic [31:0]      shd_price_q, shd_price_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_last_q, out_last_d;

    logic [7:0]          side_char;
    logic [MSG_BITS-1:0] frame_c;
    logic [SEL_W-1:0]    bit_base;

    // State, shadow and output registers; reset drops any message in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            gap_q           <= '0;
            cnt_q           <= '0;
            shd_order_ref_q <= '0;
            shd_buy_sell_q  <= 1'b0;
            shd_shares_q    <= '0;
            shd_stock_q     <= '0;
            shd_price_q     <= '0;
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_byte_q      <= 8'h00;
            out_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            gap_q           <= gap_d;
            cnt_q           <= cnt_d;
            shd_order_ref_q <= shd_order_ref_d;
            shd_buy_sell_q  <= shd_buy_sell_d;
            shd_shares_q    <= shd_shares_d;
            shd_stock_q     <= shd_stock_d;
            shd_price_q     <= shd_price_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            out_byte_q      <= out_byte_d;
            out_last_q      <= out_last_d;
        end
    end

    // Next-state: accept in IDLE, walk the byte index on handshakes, idle gap
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        gap_d           = gap_q;
        cnt_d           = cnt_q;
        shd_order_ref_d = shd_order_ref_q;
        shd_buy_sell_d  = shd_buy_sell_q;
        shd_shares_d    = shd_shares_q;
        shd_stock_d     = shd_stock_q;
        shd_price_d     = shd_price_q;

        case (state_q)
            IDLE: begin
                // in_ready_q gates acceptance so nothing is taken in the
                // cycle right after reset release
                if (in_ready_q && bus.in_valid) begin
                    shd_order_ref_d = bus.order_ref;
                    shd_buy_sell_d  = bus.buy_sell;
                    shd_shares_d    = bus.shares;
                    shd_stock_d     = bus.stock;
                    shd_price_d     = bus.price;
                    idx_d           = '0;
                    state_d         = SEND;
                end
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        idx_d = '0;
                        if (IDLE_GAP > 0) begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode from next state: byte selected from next shadow and index
    always_comb begin
        side_char   = shd_buy_sell_d ? 8'h53 : 8'h42;
`ifdef ADD_ORDER_ENC_LEN_PREFIX_EN
        frame_c     = {16'h0016, 8'h41, shd_order_ref_d, side_char,
                       shd_shares_d, shd_stock_d, shd_price_d};
`else
        frame_c     = {8'h41, shd_order_ref_d, side_char,
                       shd_shares_d, shd_stock_d, shd_price_d};
`endif
        bit_base    = SEL_W'(MSG_BITS - 8) - {idx_d, 3'b000};
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        out_last_d  = out_valid_d && (idx_d == LAST_IDX);
        out_byte_d  = out_valid_d ? frame_c[bit_base +: 8] : 8'h00;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.msg_count = cnt_q;

endmodule

// File: tb/tb_add_order_encoder.sv
// tb_add_order_encoder: directed vectors for add_order_encoder (IDLE_GAP=0
// instance for stream/backpressure/reset/wrap, IDLE_GAP=3 for back-to-back).
// Honors ADD_ORDER_ENC_LEN_PREFIX_EN for the expected stream.
module tb_add_order_encoder;

`ifdef ADD_ORDER_ENC_LEN_PREFIX_EN
    localparam int MSG_LEN = 24;
`else
    localparam int MSG_LEN = 22;
`endif
    localparam int MSG_BITS = MSG_LEN * 8;

    localparam logic [175:0] BASIC_BODY = 176'h41_0102030405060708_53_00000064_4141504C_0016E360;
    localparam logic [175:0] ISO_BODY   = 176'h41_1122334455667788_42_000003E8_4D534654_00012345;
`ifdef ADD_ORDER_ENC_LEN_PREFIX_EN
    localparam logic [MSG_BITS-1:0] BASIC_FRAME = {16'h0016, BASIC_BODY};
    localparam logic [MSG_BITS-1:0] ISO_FRAME   = {16'h0016, ISO_BODY};
`else
    localparam logic [MSG_BITS-1:0] BASIC_FRAME = BASIC_BODY;
    localparam logic [MSG_BITS-1:0] ISO_FRAME   = ISO_BODY;
`endif

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    add_order_encoder_if a0 ();
    add_order_encoder_if a3 ();

    add_order_encoder #(.IDLE_GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(a0));
    add_order_encoder #(.IDLE_GAP(3)) dut3 (.clk(clk), .rst(rst), .bus(a3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count, report mismatches
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present the basic-style bundle on dut0 and wait for acceptance
    task automatic send(input logic [63:0] oref, input logic bs, input logic [31:0] sh,
                        input logic [31:0] st, input logic [31:0] pr, input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        a0.order_ref = oref;
        a0.buy_sell  = bs;
        a0.shares    = sh;
        a0.stock     = st;
        a0.price     = pr;
        a0.in_valid  = 1'b1;
        while (!a0.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, " accept"}, 64'(a0.in_ready), 64'd1);
        @(posedge clk);
        #1;
        a0.in_valid = 1'b0;
    endtask

    // Collect n_bytes from dut0, optional 1,0,0,1 backpressure; ends on the
    // edge of the final handshake
    task automatic recv(input logic [MSG_BITS-1:0] frame, input bit bp, input int n_bytes,
                        input string tag, output int cycles);
        int       idx;
        int       p;
        bit       stalled;
        bit       rdy;
        logic [7:0] held_byte;
        logic     held_last;
        idx = 0; p = 0; stalled = 0; held_byte = 8'h00; held_last = 1'b0;
        cycles = 0;
        while (idx < n_bytes && cycles < 400) begin
            @(negedge clk);
            cycles++;
            rdy = bp ? ((p % 4) == 0 || (p % 4) == 3) : 1'b1;
            p++;
            a0.out_ready = rdy;
            if (stalled) begin
                check_eq($sformatf("%s stall valid %0d", tag, idx), 64'(a0.out_valid), 64'd1);
                check_eq($sformatf("%s stall byte %0d", tag, idx), 64'(a0.out_byte), 64'(held_byte));
                check_eq($sformatf("%s stall last %0d", tag, idx), 64'(a0.out_last), 64'(held_last));
            end
            stalled = 0;
            if (a0.out_valid) begin
                if (rdy) begin
                    check_eq($sformatf("%s byte %0d", tag, idx), 64'(a0.out_byte),
                             64'(frame[MSG_BITS-1-8*idx -: 8]));
                    check_eq($sformatf("%s last %0d", tag, idx), 64'(a0.out_last),
                             64'(idx == MSG_LEN - 1));
                    idx++;
                end else begin
                    stalled   = 1;
                    held_byte = a0.out_byte;
                    held_last = a0.out_last;
                end
            end
        end
        check_eq({tag, " bytes taken"}, 64'(idx), 64'(n_bytes));
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int cyc;
        int t0;
        int t1;
        int gap_lo;
        int idle_hi;
        bit prev_v;

        rst = 1'b1;
        a0.in_valid = 1'b0; a0.order_ref = '0; a0.buy_sell = 1'b0;
        a0.shares = '0; a0.stock = '0; a0.price = '0; a0.out_ready = 1'b0;
        a3.in_valid = 1'b0; a3.order_ref = '0; a3.buy_sell = 1'b0;
        a3.shares = '0; a3.stock = '0; a3.price = '0; a3.out_ready = 1'b0;

        // reset values
        #3;
        check_eq("rst in_ready", 64'(a0.in_ready), 64'd0);
        check_eq("rst out_valid", 64'(a0.out_valid), 64'd0);
        check_eq("rst out_byte", 64'(a0.out_byte), 64'd0);
        check_eq("rst out_last", 64'(a0.out_last), 64'd0);
        check_eq("rst msg_count", 64'(a0.msg_count), 64'd0);
        check_eq("rst gap in_ready", 64'(a3.in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post-rst in_ready", 64'(a0.in_ready), 64'd1);
        check_eq("post-rst gap in_ready", 64'(a3.in_ready), 64'd1);
        a0.out_ready = 1'b1;
        a3.out_ready = 1'b1;

        // basic sell, out_ready held high
        send(64'h0102030405060708, 1'b1, 32'd100, 32'h4141504C, 32'h0016E360, "basic");
        recv(BASIC_FRAME, 1'b0, MSG_LEN, "basic", cyc);
        check_eq("basic cycles", 64'(cyc), 64'(MSG_LEN));
        @(negedge clk);
        check_eq("basic msg_count", 64'(a0.msg_count), 64'd1);
        check_eq("basic valid drop", 64'(a0.out_valid), 64'd0);
        check_eq("basic last drop", 64'(a0.out_last), 64'd0);

        // backpressure 1,0,0,1
        send(64'h0102030405060708, 1'b1, 32'd100, 32'h4141504C, 32'h0016E360, "bp");
        recv(BASIC_FRAME, 1'b1, MSG_LEN, "bp", cyc);
        a0.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp msg_count", 64'(a0.msg_count), 64'd2);

        // buy side, inputs scrambled right after acceptance
        send(64'h1122334455667788, 1'b0, 32'h000003E8, 32'h4D534654, 32'h00012345, "iso");
        a0.order_ref = '1; a0.buy_sell = 1'b1; a0.shares = '1; a0.stock = '1; a0.price = '1;
        recv(ISO_FRAME, 1'b0, MSG_LEN, "iso", cyc);
        @(negedge clk);
        check_eq("iso msg_count", 64'(a0.msg_count), 64'd3);

        // back-to-back on the IDLE_GAP=3 instance with in_valid held
        a3.order_ref = 64'h0102030405060708; a3.buy_sell = 1'b1; a3.shares = 32'd100;
        a3.stock = 32'h4141504C; a3.price = 32'h0016E360; a3.in_valid = 1'b1;
        t0 = -1; t1 = -1; gap_lo = 0; idle_hi = 0; prev_v = 1'b0;
        for (int c = 0; c < 200 && t1 < 0; c++) begin
            @(negedge clk);
            if (a3.out_valid && !prev_v) begin
                if (t0 < 0) t0 = c;
                else t1 = c;
            end
            if (t0 >= 0 && t1 < 0 && !a3.out_valid) begin
                if (a3.in_ready) idle_hi++;
                else gap_lo++;
            end
            prev_v = a3.out_valid;
        end
        a3.in_valid = 1'b0;
        check_eq("b2b seen", 64'(t1 >= 0), 64'd1);
        check_eq("b2b spacing", 64'(t1 - t0), 64'(MSG_LEN + 1 + 3));
        check_eq("b2b gap in_ready low", 64'(gap_lo), 64'd3);
        check_eq("b2b idle in_ready high", 64'(idle_hi), 64'd1);

        // reset after byte 10
        send(64'h0102030405060708, 1'b1, 32'd100, 32'h4141504C, 32'h0016E360, "rmid");
        recv(BASIC_FRAME, 1'b0, 11, "rmid", cyc);
        #1;
        check_eq("rmid count held", 64'(a0.msg_count), 64'd3);
        check_eq("rmid still sending", 64'(a0.out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rmid in_ready", 64'(a0.in_ready), 64'd0);
        check_eq("rmid out_valid", 64'(a0.out_valid), 64'd0);
        check_eq("rmid out_byte", 64'(a0.out_byte), 64'd0);
        check_eq("rmid out_last", 64'(a0.out_last), 64'd0);
        check_eq("rmid msg_count", 64'(a0.msg_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rmid in_ready back", 64'(a0.in_ready), 64'd1);
        send(64'h0102030405060708, 1'b1, 32'd100, 32'h4141504C, 32'h0016E360, "rnext");
        recv(BASIC_FRAME, 1'b0, MSG_LEN, "rnext", cyc);
        @(negedge clk);
        check_eq("rnext msg_count", 64'(a0.msg_count), 64'd1);

        // counter wrap from 0xFFFF
        force dut0.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut0.cnt_q;
        send(64'h0102030405060708, 1'b1, 32'd100, 32'h4141504C, 32'h0016E360, "wrap");
        recv(BASIC_FRAME, 1'b0, MSG_LEN, "wrap", cyc);
        @(negedge clk);
        check_eq("wrap msg_count", 64'(a0.msg_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
